// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro: FETCH_PERF_CNT_EN.
package inst_fetch_pkg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs.
// Flush clears pointers and count; push/pop may coincide.
module fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  output fetch_entry_t  data_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= nxt(wptr_q);
      end
      if (pop_i) begin
        rptr_q <= nxt(rptr_q);
      end
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: ROM reader, redirect handling, decode buffer.
// Define FETCH_PERF_CNT_EN to add issue/stall performance counters.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rom_busy,
  output logic              rom_rd_en,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [PC_W-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int            CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = BUF_DEPTH[CW:0];

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            infl_q, infl_d;
  logic [PC_W-1:0] infl_pc_q, infl_pc_d;

  logic [CW-1:0]   occ;
  logic [CW:0]     used;
  logic            has_space;
  logic            push, pop;
  fetch_entry_t    push_ent, head;
  logic            unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  // A same-cycle pop does not free space: only registered state counts.
  assign used      = {1'b0, occ} + {{CW{1'b0}}, infl_q};
  assign has_space = (used < DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    if (!rom_busy) state_d = RUN;
      RUN:     if (rom_busy)  state_d = HOLD;
      HOLD:    if (!rom_busy) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    rom_rd_en = 1'b0;
    unique case (state_q)
      RUN:     rom_rd_en = !redirect_valid && has_space;
      default: rom_rd_en = 1'b0;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    infl_d     = rom_rd_en;
    infl_pc_d  = infl_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    end else if (rom_rd_en) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
      infl_pc_d  = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
    end
  end

  assign rom_addr = fetch_pc_q;

  // Redirect kills the returning response and overrides pop.
  assign push          = infl_q && !redirect_valid;
  assign pop           = if_valid && if_ready && !redirect_valid;
  assign push_ent.pc   = infl_pc_q;
  assign push_ent.inst = rom_inst;

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  (push_ent),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (occ)
  );

  assign if_valid = (occ != '0);
  assign if_pc    = if_valid ? head.pc   : '0;
  assign if_inst  = if_valid ? head.inst : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rom_rd_en) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if (state_q == RUN && if_ready && !if_valid) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: default instance plus a
// wrap-around instance (RESET_PC near top of memory, depth 3).
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_busy = 1'b0;
  logic        rom_rd_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc, if_inst;

  logic        w_busy = 1'b0;
  logic        w_rd_en;
  logic [31:0] w_addr, w_inst;
  logic        w_redir = 1'b0;
  logic [31:0] w_rpc = '0;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_pc, w_if_inst;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] p_issue, p_stall, wp_issue, wp_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rd_en) rom_inst <= 32'h1000_0000 + {2'b00, rom_addr[31:2]};
    if (w_rd_en)   w_inst   <= 32'h2000_0000 + {2'b00, w_addr[31:2]};
  end

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_busy       (rom_busy),
    .rom_rd_en      (rom_rd_en),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_issue_cnt (p_issue),
    .perf_stall_cnt (p_stall)
`endif
  );

  inst_fetch #(
    .RESET_PC  (32'hFFFF_FFF8),
    .BUF_DEPTH (3)
  ) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_busy       (w_busy),
    .rom_rd_en      (w_rd_en),
    .rom_addr       (w_addr),
    .rom_inst       (w_inst),
    .redirect_valid (w_redir),
    .redirect_pc    (w_rpc),
    .if_valid       (w_valid),
    .if_ready       (w_ready),
    .if_pc          (w_pc),
    .if_inst        (w_if_inst)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_issue_cnt (wp_issue),
    .perf_stall_cnt (wp_stall)
`endif
  );

  // Returns at the negedge where reset is released; that cycle is BOOT.
  task automatic do_reset(input logic busy, input logic rdy);
    @(negedge clk);
    rst_n = 1'b0;
    rom_busy = busy;
    if_ready = rdy;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    w_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    rom_busy = 1'b0;
    if_ready = 1'b1;
    #1;
    total++;
    if (rom_rd_en !== 1'b0) begin
      bad++; $display("FAIL reset_rd_en got=%b exp=0", rom_rd_en);
    end
    total++;
    if (rom_addr !== 32'h0) begin
      bad++; $display("FAIL reset_addr got=%h exp=0", rom_addr);
    end
    total++;
    if (if_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", if_valid);
    end
    total++;
    if (if_pc !== 32'h0 || if_inst !== 32'h0) begin
      bad++; $display("FAIL reset_head got=%h/%h exp=0/0", if_pc, if_inst);
    end
    total++;
    if (w_addr !== 32'hFFFF_FFF8) begin
      bad++; $display("FAIL reset_addr_w got=%h exp=fffffff8", w_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (rom_rd_en !== 1'b0) begin
      bad++; $display("FAIL boot_rd_en got=%b exp=0", rom_rd_en);
    end
  endtask

  task automatic test_stream;
    logic        en_t [7] = '{1, 1, 0, 1, 1, 0, 1};
    logic [31:0] ad_t [7] = '{0, 4, 8, 8, 12, 16, 16};
    logic        v_t  [7] = '{0, 0, 1, 1, 0, 1, 1};
    logic [31:0] pc_t [7] = '{0, 0, 0, 4, 0, 8, 12};
    do_reset(1'b0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (rom_rd_en !== en_t[c]) begin
        bad++; $display("FAIL stream_en c%0d got=%b exp=%b", c, rom_rd_en, en_t[c]);
      end
      total++;
      if (rom_addr !== ad_t[c]) begin
        bad++; $display("FAIL stream_addr c%0d got=%h exp=%h", c, rom_addr, ad_t[c]);
      end
      total++;
      if (if_valid !== v_t[c]) begin
        bad++; $display("FAIL stream_valid c%0d got=%b exp=%b", c, if_valid, v_t[c]);
      end
      if (v_t[c]) begin
        total++;
        if (if_pc !== pc_t[c] ||
            if_inst !== 32'h1000_0000 + (pc_t[c] >> 2)) begin
          bad++; $display("FAIL stream_head c%0d got=%h/%h exp=%h/%h", c,
                          if_pc, if_inst, pc_t[c], 32'h1000_0000 + (pc_t[c] >> 2));
        end
      end
    end
  endtask

  task automatic test_busy;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 9) rom_busy = 1'b0;
      #1;
      total++;
      if (rom_rd_en !== 1'b0) begin
        bad++; $display("FAIL busy_rd_en i%0d got=%b exp=0", i, rom_rd_en);
      end
    end
    @(negedge clk);
    rom_busy = 1'b1;
    #1;
    total++;
    if (rom_rd_en !== 1'b1 || rom_addr !== 32'h0) begin
      bad++; $display("FAIL busy_first_issue got=%b/%h exp=1/0", rom_rd_en, rom_addr);
    end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) rom_busy = 1'b0;
      #1;
      total++;
      if (rom_rd_en !== 1'b0) begin
        bad++; $display("FAIL hold_rd_en i%0d got=%b exp=0", i, rom_rd_en);
      end
      if (i == 2) begin
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
          bad++; $display("FAIL hold_drain got=%b/%h exp=1/0", if_valid, if_pc);
        end
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (rom_rd_en !== 1'b1 || rom_addr !== 32'h4) begin
      bad++; $display("FAIL hold_resume got=%b/%h exp=1/4", rom_rd_en, rom_addr);
    end
  endtask

  task automatic test_full;
    int issues = 0;
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (rom_rd_en === 1'b1) begin
        total++;
        if (rom_addr !== 32'(4 * issues)) begin
          bad++; $display("FAIL full_addr c%0d got=%h exp=%h", c, rom_addr, 4 * issues);
        end
        issues++;
      end
      if (c >= 2) begin
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h1000_0000) begin
          bad++; $display("FAIL full_head c%0d got=%b/%h/%h exp=1/0/10000000",
                          c, if_valid, if_pc, if_inst);
        end
      end
    end
    total++;
    if (issues != 2) begin
      bad++; $display("FAIL full_issue_count got=%0d exp=2", issues);
    end
    @(negedge clk);
    if_ready = 1'b1;
    #1;
    total++;
    if (rom_rd_en !== 1'b0 || if_pc !== 32'h0) begin
      bad++; $display("FAIL full_pop_cycle got=%b/%h exp=0/0", rom_rd_en, if_pc);
    end
    @(negedge clk);
    if_ready = 1'b0;
    #1;
    total++;
    if (rom_rd_en !== 1'b1 || rom_addr !== 32'h8 || if_pc !== 32'h4) begin
      bad++; $display("FAIL full_after_pop got=%b/%h/%h exp=1/8/4", rom_rd_en, rom_addr, if_pc);
    end
  endtask

  task automatic test_redirect;
    bit seen8 = 0;
    bit got   = 0;
    do_reset(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (rom_rd_en !== 1'b1 || rom_addr !== 32'h8) begin
      bad++; $display("FAIL redir_pre got=%b/%h exp=1/8", rom_rd_en, rom_addr);
    end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    total++;
    if (rom_rd_en !== 1'b0) begin
      bad++; $display("FAIL redir_no_issue got=%b exp=0", rom_rd_en);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    total++;
    if (if_valid !== 1'b0 || rom_rd_en !== 1'b1 || rom_addr !== 32'h100) begin
      bad++; $display("FAIL redir_next got=%b/%b/%h exp=0/1/100", if_valid, rom_rd_en, rom_addr);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (if_valid === 1'b1 && if_pc === 32'h8) seen8 = 1;
      if (if_valid === 1'b1 && !got) begin
        got = 1;
        total++;
        if (if_pc !== 32'h100 || if_inst !== 32'h1000_0040 || c != 1) begin
          bad++; $display("FAIL redir_first got=%h/%h c%0d exp=100/10000040 c1",
                          if_pc, if_inst, c);
        end
      end
    end
    total++;
    if (seen8 || !got) begin
      bad++; $display("FAIL redir_stale got=seen8:%0d got:%0d exp=0/1", seen8, got);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] iq[$];
    logic [31:0] pq[$];
    do_reset(1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (w_rd_en === 1'b1) iq.push_back(w_addr);
      if (w_valid === 1'b1) pq.push_back(w_pc);
    end
    total++;
    if (iq.size() < 3) begin
      bad++; $display("FAIL wrap_issue_count got=%0d exp>=3", iq.size());
    end else begin
      total++;
      if (iq[0] !== 32'hFFFF_FFF8 || iq[1] !== 32'hFFFF_FFFC || iq[2] !== 32'h0) begin
        bad++; $display("FAIL wrap_addr got=%h,%h,%h exp=fffffff8,fffffffc,0",
                        iq[0], iq[1], iq[2]);
      end
    end
    total++;
    if (pq.size() < 3) begin
      bad++; $display("FAIL wrap_pop_count got=%0d exp>=3", pq.size());
    end else begin
      total++;
      if (pq[0] !== 32'hFFFF_FFF8 || pq[1] !== 32'hFFFF_FFFC || pq[2] !== 32'h0) begin
        bad++; $display("FAIL wrap_pc got=%h,%h,%h exp=fffffff8,fffffffc,0",
                        pq[0], pq[1], pq[2]);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic        v_t [3] = '{0, 0, 1};
    do_reset(1'b0, 1'b1);
    w_ready = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFF8) begin
      bad++; $display("FAIL midrst_pre got=%b/%h exp=1/fffffff8", w_valid, w_pc);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (w_valid !== 1'b0 || w_rd_en !== 1'b0 || w_pc !== 32'h0) begin
      bad++; $display("FAIL midrst_now got=%b/%b/%h exp=0/0/0", w_valid, w_rd_en, w_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    w_ready = 1'b1;
    #1;
    total++;
    if (w_valid !== 1'b0 || w_addr !== 32'hFFFF_FFF8) begin
      bad++; $display("FAIL midrst_boot got=%b/%h exp=0/fffffff8", w_valid, w_addr);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      total++;
      if (w_valid !== v_t[c]) begin
        bad++; $display("FAIL midrst_valid c%0d got=%b exp=%b", c, w_valid, v_t[c]);
      end
      if (c == 0) begin
        total++;
        if (w_rd_en !== 1'b1 || w_addr !== 32'hFFFF_FFF8) begin
          bad++; $display("FAIL midrst_restart got=%b/%h exp=1/fffffff8", w_rd_en, w_addr);
        end
      end
      if (c == 2) begin
        total++;
        if (w_pc !== 32'hFFFF_FFF8 || w_if_inst !== 32'h2000_0000 + 32'h3FFF_FFFE) begin
          bad++; $display("FAIL midrst_head got=%h/%h exp=fffffff8/5ffffffe", w_pc, w_if_inst);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int n_iss = 0;
    int n_pop = 0;
    do_reset(1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if_ready = (c % 3 != 2);
      #1;
      if (rom_rd_en === 1'b1) begin
        total++;
        if (rom_addr !== 32'(4 * n_iss)) begin
          bad++; $display("FAIL b2b_addr c%0d got=%h exp=%h", c, rom_addr, 4 * n_iss);
        end
        n_iss++;
      end
      if (if_valid === 1'b1 && if_ready === 1'b1) begin
        total++;
        if (if_pc !== 32'(4 * n_pop) || if_inst !== 32'h1000_0000 + 32'(n_pop)) begin
          bad++; $display("FAIL b2b_pop c%0d got=%h/%h exp=%h/%h", c, if_pc, if_inst,
                          4 * n_pop, 32'h1000_0000 + 32'(n_pop));
        end
        n_pop++;
      end
    end
    total++;
    if (n_pop < 10) begin
      bad++; $display("FAIL b2b_progress got=%0d exp>=10", n_pop);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_busy();
    test_full();
    test_redirect();
    test_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
